// File: rtl/main_memory.sv
// Line-granular backing memory answering cache fills and writebacks after a fixed latency.
// Build option MAIN_MEM_STATS_EN adds saturating accepted-read/accepted-write counters.
//   state | meaning
//   IDLE  | waiting for a granted request
//   WAIT  | latency down-counter running
//   RESP  | fill_out pulse, response valid
module main_memory #(
    parameter int CACHE_LINE_WIDTH = 128,
    parameter int ADDRESS_WIDTH    = 32,
    parameter int MEM_LINES        = 1024,
    parameter int MEM_LATENCY      = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_in,
    input  logic                        req_write_in,
    input  logic [ADDRESS_WIDTH-1:0]    req_addr_in,
    input  logic [CACHE_LINE_WIDTH-1:0] req_data_in,
    output logic                        fill_out,
    output logic [CACHE_LINE_WIDTH-1:0] fill_data_out,
    output logic [ADDRESS_WIDTH-1:0]    fill_addr_out,
`ifdef MAIN_MEM_STATS_EN
    output logic                        busy_out,
    output logic [31:0]                 read_count_out,
    output logic [31:0]                 write_count_out
`else
    output logic                        busy_out
`endif
);

    localparam int OFF   = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0]         LAT_M1   = CNT_W'(MEM_LATENCY - 1);
    localparam logic [ADDRESS_WIDTH-1:0] OFF_MASK = ADDRESS_WIDTH'((64'd1 << OFF) - 64'd1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0]    addr_q;
    logic [CACHE_LINE_WIDTH-1:0] resp_data_q;
    logic [CACHE_LINE_WIDTH-1:0] fill_data_q;
    logic [ADDRESS_WIDTH-1:0]    fill_addr_q;
    logic [CACHE_LINE_WIDTH-1:0] mem_q [MEM_LINES];

    logic                        accept;
    logic [IDX_W-1:0]            line_idx;
    logic [ADDRESS_WIDTH-1:0]    aligned_addr;
    logic [CACHE_LINE_WIDTH-1:0] line_now;

    assign line_idx     = req_addr_in[OFF +: IDX_W];
    assign aligned_addr = req_addr_in & ~OFF_MASK;
    assign line_now     = req_write_in ? req_data_in : mem_q[line_idx];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_in) begin
                    accept  = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = (LAT_M1 == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Array and response line have no reset: contents survive a reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (req_write_in) begin
                mem_q[line_idx] <= req_data_in;
            end
            resp_data_q <= line_now;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            fill_data_q <= '0;
            fill_addr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= aligned_addr;
            end
            // On a 1-cycle latency RESP is entered on the accept edge, so bypass the latches.
            if (state_d == RESP) begin
                fill_data_q <= accept ? line_now : resp_data_q;
                fill_addr_q <= accept ? aligned_addr : addr_q;
            end
        end
    end

    assign fill_out      = (state_q == RESP);
    assign fill_data_out = fill_data_q;
    assign fill_addr_out = fill_addr_q;
    assign busy_out      = (state_q != IDLE);

`ifdef MAIN_MEM_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (accept) begin
            if (req_write_in && (wr_cnt_q != '1)) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
            if (!req_write_in && (rd_cnt_q != '1)) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign read_count_out  = rd_cnt_q;
    assign write_count_out = wr_cnt_q;
`endif

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: three instances at latencies 5, 1 and 7.
module tb_main_memory;

    localparam int LW = 128;
    localparam int AW = 32;
    localparam logic [LW-1:0] D0 = 128'hDEADBEEF_00112233_44556677_8899AABB;
    localparam logic [LW-1:0] D1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [LW-1:0] D2 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    localparam logic [LW-1:0] D3 = 128'hCAFEF00D_11112222_33334444_55556666;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          req_v   [3];
    logic          wr_v    [3];
    logic [AW-1:0] addr_v  [3];
    logic [LW-1:0] wdata_v [3];
    logic          fill_v  [3];
    logic [LW-1:0] fdata_v [3];
    logic [AW-1:0] faddr_v [3];
    logic          busy_v  [3];
`ifdef MAIN_MEM_STATS_EN
    logic [31:0]   rcnt_v  [3];
    logic [31:0]   wcnt_v  [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        main_memory #(
            .CACHE_LINE_WIDTH(LW),
            .ADDRESS_WIDTH   (AW),
            .MEM_LINES       (1024),
            .MEM_LATENCY     ((g == 0) ? 5 : (g == 1) ? 1 : 7)
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .req_in         (req_v[g]),
            .req_write_in   (wr_v[g]),
            .req_addr_in    (addr_v[g]),
            .req_data_in    (wdata_v[g]),
            .fill_out       (fill_v[g]),
            .fill_data_out  (fdata_v[g]),
            .fill_addr_out  (faddr_v[g]),
`ifdef MAIN_MEM_STATS_EN
            .busy_out       (busy_v[g]),
            .read_count_out (rcnt_v[g]),
            .write_count_out(wcnt_v[g])
`else
            .busy_out       (busy_v[g])
`endif
        );
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input int d, input logic wr, input logic [AW-1:0] a,
                             input logic [LW-1:0] dat);
        @(negedge clk);
        req_v[d]   = 1'b1;
        wr_v[d]    = wr;
        addr_v[d]  = a;
        wdata_v[d] = dat;
        @(posedge clk);
    endtask

    // Cycle 1 is the sample right after the accept edge.
    task automatic wait_fill(input int d, output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!busy_v[d]) busy_ok = 1'b0;
            if (fill_v[d]) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic end_req(input int d, input string tag);
        req_v[d] = 1'b0;
        @(negedge clk);
        chk({tag, " pulse width"}, LW'(fill_v[d]), '0);
        chk({tag, " back idle"}, LW'(busy_v[d]), '0);
    endtask

    task automatic txn(input int d, input logic wr, input logic [AW-1:0] a,
                       input logic [LW-1:0] dat, input int exp_lat,
                       input logic [LW-1:0] exp_data, input logic [AW-1:0] exp_addr,
                       input string tag);
        int lat;
        bit bok;
        start_req(d, wr, a, dat);
        wait_fill(d, lat, bok);
        chk({tag, " latency"}, LW'(lat), LW'(exp_lat));
        chk({tag, " busy"}, LW'(bok), LW'(1));
        chk({tag, " data"}, fdata_v[d], exp_data);
        chk({tag, " addr"}, LW'(faddr_v[d]), LW'(exp_addr));
        end_req(d, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  lat;
        bit  bok;
        bit  seen;
        for (int d = 0; d < 3; d++) begin
            req_v[d]   = 1'b0;
            wr_v[d]    = 1'b0;
            addr_v[d]  = '0;
            wdata_v[d] = '0;
        end
        reset = 1'b1;
        #12;
        for (int d = 0; d < 3; d++) begin
            chk("reset fill", LW'(fill_v[d]), '0);
            chk("reset busy", LW'(busy_v[d]), '0);
            chk("reset data", fdata_v[d], '0);
            chk("reset addr", LW'(faddr_v[d]), '0);
        end
        @(negedge clk);
        reset = 1'b0;

        txn(0, 1'b1, 32'h0000_1000, D0, 5, D0, 32'h0000_1000, "wr lat5");
        txn(0, 1'b0, 32'h0000_100C, '0, 5, D0, 32'h0000_1000, "rd lat5");

        txn(1, 1'b1, 32'h0000_0020, D1, 1, D1, 32'h0000_0020, "wr lat1");
        txn(1, 1'b0, 32'h0000_002F, '0, 1, D1, 32'h0000_0020, "rd lat1");
        txn(2, 1'b1, 32'h0000_3004, D2, 7, D2, 32'h0000_3000, "wr lat7");
        txn(2, 1'b0, 32'h0000_3000, '0, 7, D2, 32'h0000_3000, "rd lat7");

        txn(0, 1'b1, 32'h0000_4010, D3, 5, D3, 32'h0000_4010, "wrap wr");
        txn(0, 1'b0, 32'h0000_0010, '0, 5, D3, 32'h0000_0010, "wrap rd");

        start_req(0, 1'b0, 32'h0000_1008, '0);
        #1 addr_v[0] = 32'h0000_0014;
        wait_fill(0, lat, bok);
        chk("held latency", LW'(lat), LW'(5));
        chk("held data", fdata_v[0], D0);
        chk("held addr", LW'(faddr_v[0]), LW'(32'h0000_1000));
        @(negedge clk);
        chk("held gap fill", LW'(fill_v[0]), '0);
        chk("held gap busy", LW'(busy_v[0]), '0);
        wait_fill(0, lat, bok);
        chk("second latency", LW'(lat), LW'(5));
        chk("second busy", LW'(bok), LW'(1));
        chk("second data", fdata_v[0], D3);
        chk("second addr", LW'(faddr_v[0]), LW'(32'h0000_0010));
        end_req(0, "second");

        start_req(0, 1'b0, 32'h0000_100C, '0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst abort fill", LW'(fill_v[0]), '0);
        chk("rst abort busy", LW'(busy_v[0]), '0);
        chk("rst abort data", fdata_v[0], '0);
        chk("rst abort addr", LW'(faddr_v[0]), '0);
        req_v[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (fill_v[0]) seen = 1'b1;
        end
        chk("no fill after rst", LW'(seen), '0);
        txn(0, 1'b0, 32'h0000_1000, '0, 5, D0, 32'h0000_1000, "post rst rd");

`ifdef MAIN_MEM_STATS_EN
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("stats clr rd", LW'(rcnt_v[0]), '0);
        chk("stats clr wr", LW'(wcnt_v[0]), '0);
        txn(0, 1'b0, 32'h0000_1000, '0, 5, D0, 32'h0000_1000, "st rd1");
        txn(0, 1'b1, 32'h0000_2000, D1, 5, D1, 32'h0000_2000, "st wr1");
        txn(0, 1'b0, 32'h0000_2004, '0, 5, D1, 32'h0000_2000, "st rd2");
        txn(0, 1'b1, 32'h0000_2010, D2, 5, D2, 32'h0000_2010, "st wr2");
        txn(0, 1'b0, 32'h0000_2010, '0, 5, D2, 32'h0000_2010, "st rd3");
        chk("stats rd count", LW'(rcnt_v[0]), LW'(3));
        chk("stats wr count", LW'(wcnt_v[0]), LW'(2));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("stats rst rd", LW'(rcnt_v[0]), '0);
        chk("stats rst wr", LW'(wcnt_v[0]), '0);
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
